// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between two requesters.
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN to make requester 0 always win.
module data_mem_arbiter #(
  parameter int Bits    = 16,
  parameter int MemSize = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            we0,
  input  logic [Bits-1:0] addr0,
  input  logic [Bits-1:0] wdata0,
  output logic            ack0,
  output logic            err0,
  output logic [Bits-1:0] rdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [Bits-1:0] addr1,
  input  logic [Bits-1:0] wdata1,
  output logic            ack1,
  output logic            err1,
  output logic [Bits-1:0] rdata1,
  output logic [Bits-1:0] mem_access_addr,
  output logic [Bits-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read,
  input  logic [Bits-1:0] mem_read_data,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [Bits-1:0] Lim = Bits'(MemSize);

  state_t          state;
  state_t          state_nx;
  logic            sel;
  logic            err_q;
  logic            grant;
  logic            win;
  logic            win_we;
  logic            win_ok;
  logic [Bits-1:0] win_addr;
  logic [Bits-1:0] win_wdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic last_grant;

  assign win = (req0 && req1) ? ~last_grant : ~req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= win;
    end
  end
`endif

  assign grant     = (state == IDLE) && (req0 || req1);
  assign win_we    = win ? we1 : we0;
  assign win_addr  = win ? addr1 : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign win_ok    = win_addr < Lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Enables live for the ACCESS cycle only; addr/data hold until next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel             <= 1'b0;
      err_q           <= 1'b0;
      mem_access_addr <= '0;
      mem_write_data  <= '0;
      mem_write_en    <= 1'b0;
      mem_read        <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
    end else begin
      if (grant) begin
        sel             <= win;
        err_q           <= ~win_ok;
        mem_access_addr <= win_addr;
        mem_write_data  <= win_wdata;
        mem_write_en    <= win_ok & win_we;
        mem_read        <= win_ok & ~win_we;
      end else begin
        mem_write_en <= 1'b0;
        mem_read     <= 1'b0;
      end
      if (mem_read && !sel) rdata0 <= mem_read_data;
      if (mem_read && sel)  rdata1 <= mem_read_data;
    end
  end

  assign ack0 = (state == RESP) && !sel;
  assign ack1 = (state == RESP) && sel;
  assign err0 = ack0 && err_q;
  assign err1 = ack1 && err_q;
  assign busy = state != IDLE;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: random two-requester traffic checked against a
// transaction-level model of the arbiter and the memory contents.
module tb_data_mem_arbiter;
  localparam int Bits    = 16;
  localparam int MemSize = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            t_req   [2];
  logic            t_we    [2];
  logic [Bits-1:0] t_addr  [2];
  logic [Bits-1:0] t_wdata [2];
  logic            ack0, ack1, err0, err1;
  logic [Bits-1:0] rdata0, rdata1;
  logic [Bits-1:0] mem_access_addr, mem_write_data, mem_read_data;
  logic            mem_write_en, mem_read, busy;

  int total = 0;
  int bad = 0;

  logic [Bits-1:0] ram     [MemSize];
  logic [Bits-1:0] ref_mem [MemSize];
  logic [Bits-1:0] picks   [12];

  // model state
  int              cyc;
  int              next_free;
  int              last;
  bit              g_act;
  int              g_edge;
  int              g_port;
  bit              g_we;
  logic [Bits-1:0] g_addr, g_wdata;
  bit              pend    [2];
  bit              granted [2];
  bit              p_we    [2];
  logic [Bits-1:0] p_addr  [2];
  logic [Bits-1:0] p_wdata [2];
  logic [Bits-1:0] exp_rd  [2];

  always #5 clk = ~clk;

  assign mem_read_data = ram[mem_access_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write_en) ram[mem_access_addr[7:0]] <= mem_write_data;
  end

  data_mem_arbiter #(.Bits(Bits), .MemSize(MemSize)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0            (t_req[0]),
    .we0             (t_we[0]),
    .addr0           (t_addr[0]),
    .wdata0          (t_wdata[0]),
    .ack0            (ack0),
    .err0            (err0),
    .rdata0          (rdata0),
    .req1            (t_req[1]),
    .we1             (t_we[1]),
    .addr1           (t_addr[1]),
    .wdata1          (t_wdata[1]),
    .ack1            (ack1),
    .err1            (err1),
    .rdata1          (rdata1),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    g_act     = 0;
    last      = 1;
    next_free = cyc + 1;
    for (int p = 0; p < 2; p++) begin
      pend[p]    = 0;
      granted[p] = 0;
      exp_rd[p]  = '0;
      t_req[p]   = 1'b0;
      t_we[p]    = 1'b0;
      t_addr[p]  = '0;
      t_wdata[p] = '0;
    end
  endtask

  task automatic present(input int p);
    t_req[p]   = 1'b1;
    t_we[p]    = p_we[p];
    t_addr[p]  = p_addr[p];
    t_wdata[p] = p_wdata[p];
  endtask

  // Arbitration decision for the coming edge.
  task automatic decide();
    int w;
    bit c0, c1;
    w  = 0;
    c0 = pend[0] && !granted[0];
    c1 = pend[1] && !granted[1];
    if (!g_act && cyc + 1 >= next_free && (c0 || c1)) begin
      if (c0 && c1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (last == 0) ? 1 : 0;
`endif
      end else begin
        w = c1 ? 1 : 0;
      end
      g_act      = 1;
      g_edge     = cyc + 1;
      g_port     = w;
      g_we       = p_we[w];
      g_addr     = p_addr[w];
      g_wdata    = p_wdata[w];
      granted[w] = 1;
      last       = w;
      next_free  = cyc + 4;
    end
  endtask

  task automatic step(input int new_pct);
    bit in_g, in_r, ok;
    @(posedge clk);
    cyc++;
    #1;
    in_g = g_act && cyc == g_edge;
    in_r = g_act && cyc == g_edge + 1;
    ok   = g_addr < MemSize;
    if (in_r) begin
      if (ok && g_we)  ref_mem[g_addr[7:0]] = g_wdata;
      if (ok && !g_we) exp_rd[g_port] = ref_mem[g_addr[7:0]];
      pend[g_port]    = 0;
      granted[g_port] = 0;
    end
    chk("busy", busy, in_g || in_r);
    chk("wen", mem_write_en, in_g && ok && g_we);
    chk("mrd", mem_read, in_g && ok && !g_we);
    if (in_g) begin
      chk("maddr", mem_access_addr, g_addr);
      if (g_we) chk("mwdata", mem_write_data, g_wdata);
    end
    chk("ack0", ack0, in_r && g_port == 0);
    chk("ack1", ack1, in_r && g_port == 1);
    chk("err0", err0, in_r && g_port == 0 && !ok);
    chk("err1", err1, in_r && g_port == 1 && !ok);
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    if (in_r) g_act = 0;
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && granted[p]) begin
        // post-grant input changes, including dropping req, must be ignored
        if ($urandom_range(0, 3) == 0) begin
          t_req[p]   = 1'($urandom_range(0, 1));
          t_we[p]    = 1'($urandom_range(0, 1));
          t_addr[p]  = Bits'($urandom);
          t_wdata[p] = Bits'($urandom);
        end
      end else if (!pend[p]) begin
        if ($urandom_range(0, 99) < new_pct) begin
          pend[p]    = 1;
          granted[p] = 0;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = picks[$urandom_range(0, 11)];
          p_wdata[p] = Bits'($urandom);
          present(p);
        end else begin
          t_req[p]  = 1'b0;
          t_addr[p] = Bits'($urandom);
        end
      end
    end
    decide();
  endtask

  initial begin
    int n;
    picks = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd7, 16'd100,
              16'd254, 16'd255, 16'd256, 16'd257, 16'hFFFF};
    for (int i = 0; i < MemSize; i++) begin
      ram[i]     = Bits'($urandom);
      ref_mem[i] = ram[i];
    end
    cyc = 0;
    model_reset();
    t_req[0] = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_err0", err0, 0);
      chk("rst_err1", err1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_wen", mem_write_en, 0);
      chk("rst_mrd", mem_read, 0);
      chk("rst_maddr", mem_access_addr, 0);
      chk("rst_mwdata", mem_write_data, 0);
      chk("rst_busy", busy, 0);
    end
    rst_n = 1'b1;
    model_reset();

    repeat (400) step(35);
    repeat (60) step(100);
    repeat (200) step(50);

    n = 0;
    while ((g_act || pend[0] || pend[1] || cyc + 1 < next_free) && n < 20) begin
      step(0);
      n++;
    end
    chk("drain", {31'b0, g_act || pend[0] || pend[1]}, 0);

    // write to addr 7 interrupted by reset while in ACCESS
    pend[0]    = 1;
    granted[0] = 0;
    p_we[0]    = 1'b1;
    p_addr[0]  = 16'd7;
    p_wdata[0] = (ref_mem[7] == 16'h1234) ? 16'h4321 : 16'h1234;
    present(0);
    decide();
    step(0);
    chk("abort_wen_pre", mem_write_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wen", mem_write_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack0", ack0, 0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("abort_hold_ack0", ack0, 0);
      chk("abort_hold_ack1", ack1, 0);
    end
    chk("abort_mem7", ram[7], ref_mem[7]);
    rst_n = 1'b1;
    model_reset();

    repeat (300) step(40);
    repeat (40) step(100);
    repeat (10) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
